// File: rtl/vram_pkg.sv
// Shared VRAM scan types and default sizes for the display-side VRAM reader.
package vram_pkg;

    localparam int unsigned VRAM_ADDR_W      = 13;
    localparam int unsigned VRAM_DATA_W      = 32;
    localparam int unsigned VRAM_FRAME_WORDS = 4800;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } scan_state_t;

    typedef logic [VRAM_DATA_W-1:0] vram_word_t;

endpackage

// File: rtl/vram_scan_fifo.sv
// Synchronous FIFO holding {sof, data} entries between VRAM capture and the pixel port.
module vram_scan_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    // Storage write; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // The credit scheme upstream must never push into a full FIFO without a pop.
    assert property (@(posedge clk) disable iff (rst) !(push && full && !pop_ok));

endmodule

// File: rtl/vram_scan_reader.sv
// Display-side VRAM scan reader: issues credit-limited word reads across one frame and
// streams the returned words in address order over a valid/ready pixel interface.
// Optional feature macro VRAM_SCAN_UNDERRUN_CNT_EN adds the underrun_cnt output.
module vram_scan_reader
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_W      = VRAM_ADDR_W,
    parameter int unsigned DATA_W      = VRAM_DATA_W,
    parameter int unsigned FRAME_WORDS = VRAM_FRAME_WORDS,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_load,
    input  logic [DATA_W-1:0] vram_data,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_sof,
    input  logic              pix_ready,
    output logic              busy,
    output logic              frame_done
`ifdef VRAM_SCAN_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    scan_state_t       state;
    scan_state_t       state_next;
    logic              load_next;
    logic [ADDR_W-1:0] addr_next;
    logic              done_next;

    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  inflight_next;
    logic [SUM_W-1:0]  sum_next;

    logic [RD_LAT-1:0] ret_v_sr;
    logic [RD_LAT-1:0] ret_sof_sr;
    logic              ret_valid;
    logic              ret_sof;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_head;
    logic              pop;

    assign ret_valid = ret_v_sr[RD_LAT-1];
    assign ret_sof   = ret_sof_sr[RD_LAT-1];
    assign pix_valid = !fifo_empty;
    assign pix_data  = fifo_head[DATA_W-1:0];
    assign pix_sof   = fifo_head[DATA_W];
    assign pop       = pix_valid && pix_ready;

    // Loads issued but not yet captured, and the credit total seen by next cycle's issue decision.
    assign inflight_next = inflight + CNT_W'(vram_load) - CNT_W'(ret_valid);
    assign sum_next      = SUM_W'(fifo_count) + SUM_W'(inflight) + SUM_W'(vram_load) - SUM_W'(pop);

    // Output buffer; capture writes the tagged return word in the cycle it arrives.
    vram_scan_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ret_valid),
        .push_data ({ret_sof, vram_data}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // Return tagging: valid/sof ride a RD_LAT-deep shift register alongside the VRAM access.
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_v_sr   <= '0;
            ret_sof_sr <= '0;
        end else begin
            ret_v_sr[0]   <= vram_load;
            ret_sof_sr[0] <= vram_load && (vram_addr == '0);
            for (int i = 1; i < RD_LAT; i++) begin
                ret_v_sr[i]   <= ret_v_sr[i-1];
                ret_sof_sr[i] <= ret_sof_sr[i-1];
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vram_load  <= 1'b0;
            vram_addr  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            inflight   <= '0;
        end else begin
            state      <= state_next;
            vram_load  <= load_next;
            vram_addr  <= addr_next;
            busy       <= (state_next != IDLE);
            frame_done <= done_next;
            inflight   <= inflight_next;
        end
    end

    // Next-state, issue and completion decisions.
    always_comb begin
        state_next = state;
        load_next  = 1'b0;
        addr_next  = vram_addr;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                    load_next  = 1'b1;
                    addr_next  = '0;
                end
            end
            FETCH: begin
                if (vram_load) begin
                    if (vram_addr == LAST_ADDR) begin
                        state_next = DRAIN;
                    end else begin
                        addr_next = vram_addr + ADDR_W'(1);
                    end
                end
                load_next = (state_next == FETCH) && (sum_next < SUM_W'(FIFO_DEPTH));
            end
            DRAIN: begin
                // Last word leaves when the FIFO holds one entry and nothing is still returning.
                if (pop && (fifo_count == CNT_W'(1)) && (inflight == '0)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef VRAM_SCAN_UNDERRUN_CNT_EN
    // Count busy cycles where the consumer was ready but no word was available.
    always_ff @(posedge clk) begin
        if (rst || ((state == IDLE) && start)) begin
            underrun_cnt <= '0;
        end else if (busy && pix_ready && !pix_valid && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vram_scan_reader.sv
// Self-checking bench for vram_scan_reader: two instances (8 words / RD_LAT=1 and
// 100 words / RD_LAT=3) driven by a VRAM latency model and a randomized pixel consumer.
module tb_vram_scan_reader;
    import vram_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_s [2];
    logic       ready_s [2];
    logic       load_s  [2];
    logic       valid_s [2];
    logic       sof_s   [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    logic [12:0] addr_s [2];
    vram_word_t vdata_s [2];
    vram_word_t pdata_s [2];
    vram_word_t salt    [2];
`ifdef VRAM_SCAN_UNDERRUN_CNT_EN
    logic [15:0] und_s  [2];
`endif

    int checks   = 0;
    int failures = 0;
    int r_accepted, r_first_valid, r_done, r_loads;

    // VRAM history for the latency model
    logic        hv [2][4];
    logic [12:0] ha [2][4];

    always #5 clk = ~clk;

    function automatic vram_word_t word_of(input int u, input int a, input vram_word_t s);
        if (u == 0) return 32'(a * 3);
        return 32'(a * 7) + s;
    endfunction

    vram_scan_reader #(.FRAME_WORDS(8), .RD_LAT(1), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .vram_addr(addr_s[0]), .vram_load(load_s[0]),
        .vram_data(vdata_s[0]), .pix_valid(valid_s[0]), .pix_data(pdata_s[0]), .pix_sof(sof_s[0]),
        .pix_ready(ready_s[0]), .busy(busy_s[0]), .frame_done(done_s[0])
`ifdef VRAM_SCAN_UNDERRUN_CNT_EN
        , .underrun_cnt(und_s[0])
`endif
    );

    vram_scan_reader #(.FRAME_WORDS(100), .RD_LAT(3), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .vram_addr(addr_s[1]), .vram_load(load_s[1]),
        .vram_data(vdata_s[1]), .pix_valid(valid_s[1]), .pix_data(pdata_s[1]), .pix_sof(sof_s[1]),
        .pix_ready(ready_s[1]), .busy(busy_s[1]), .frame_done(done_s[1])
`ifdef VRAM_SCAN_UNDERRUN_CNT_EN
        , .underrun_cnt(und_s[1])
`endif
    );

    // VRAM: data valid exactly RD_LAT cycles after a load, junk otherwise
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            hv[u][0] <= load_s[u];
            ha[u][0] <= addr_s[u];
            for (int k = 1; k < 4; k++) begin
                hv[u][k] <= hv[u][k-1];
                ha[u][k] <= ha[u][k-1];
            end
        end
    end
    assign vdata_s[0] = hv[0][0] ? word_of(0, int'(ha[0][0]), salt[0]) : 32'hDEAD_BEEF;
    assign vdata_s[1] = hv[1][2] ? word_of(1, int'(ha[1][2]), salt[1]) : 32'hDEAD_BEEF;

    task automatic pulse_start(input int u);
        start_s[u] = 1'b1;
        @(posedge clk); #1;
        start_s[u] = 1'b0;
    endtask

    // Consume up to stop_after words of a frame, checking order, sof, hold and load addresses.
    task automatic consume(input int u, input int nwords, input int pct, input int stop_after,
                           input int restart_cyc, input int load_base);
        int cyc;
        int nl;
        logic stall;
        logic rdy;
        vram_word_t held_data;
        logic held_sof;
        r_accepted = 0; r_first_valid = -1; r_done = 0;
        nl = load_base; stall = 1'b0; held_data = '0; held_sof = 1'b0; cyc = 1;
        while (r_accepted < nwords && r_accepted < stop_after) begin
            if (cyc > 4000) begin
                checks++; failures++;
                $display("FAIL consume_timeout unit=%0d accepted=%0d required=%0d", u, r_accepted, nwords);
                break;
            end
            start_s[u] = (cyc == restart_cyc);
            if (done_s[u]) r_done++;
            if (load_s[u]) begin
                checks++;
                if (addr_s[u] !== 13'(nl)) begin
                    failures++;
                    $display("FAIL load_addr unit=%0d got=%0d required=%0d", u, addr_s[u], nl);
                end
                nl++;
            end
            if (stall) begin
                checks++;
                if (valid_s[u] !== 1'b1 || pdata_s[u] !== held_data || sof_s[u] !== held_sof) begin
                    failures++;
                    $display("FAIL hold unit=%0d got=%b/%h/%b required=1/%h/%b", u, valid_s[u],
                             pdata_s[u], sof_s[u], held_data, held_sof);
                end
            end
            if (valid_s[u] && r_first_valid < 0) r_first_valid = cyc;
            rdy = ($urandom_range(99) < pct);
            ready_s[u] = rdy;
            if (valid_s[u] && rdy) begin
                checks++;
                if (pdata_s[u] !== word_of(u, r_accepted, salt[u]) || sof_s[u] !== (r_accepted == 0)) begin
                    failures++;
                    $display("FAIL word unit=%0d idx=%0d got=%h sof=%b required=%h sof=%b", u, r_accepted,
                             pdata_s[u], sof_s[u], word_of(u, r_accepted, salt[u]), (r_accepted == 0));
                end
                r_accepted++;
            end
            stall = valid_s[u] && !rdy;
            held_data = pdata_s[u];
            held_sof = sof_s[u];
            @(posedge clk); #1;
            cyc++;
        end
        start_s[u] = 1'b0;
        ready_s[u] = 1'b0;
        r_loads = nl;
        if (r_accepted == nwords) begin
            checks++;
            if (done_s[u] !== 1'b1 || busy_s[u] !== 1'b0) begin
                failures++;
                $display("FAIL frame_done_pulse unit=%0d done=%b busy=%b required done=1 busy=0",
                         u, done_s[u], busy_s[u]);
            end
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                checks++;
                if (done_s[u] || valid_s[u] || load_s[u] || busy_s[u]) begin
                    failures++;
                    $display("FAIL post_frame_idle unit=%0d done=%b valid=%b load=%b busy=%b required all 0",
                             u, done_s[u], valid_s[u], load_s[u], busy_s[u]);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic act;
        act = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            for (int u = 0; u < 2; u++)
                act |= load_s[u] | valid_s[u] | busy_s[u] | done_s[u];
        end
        checks++;
        if (act !== 1'b0) begin
            failures++;
            $display("FAIL idle_activity got=%b required=0", act);
        end
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (load_s[u] !== 1'b0 || valid_s[u] !== 1'b0 || busy_s[u] !== 1'b0 ||
                done_s[u] !== 1'b0 || addr_s[u] !== 13'd0) begin
                failures++;
                $display("FAIL reset_state unit=%0d load=%b valid=%b busy=%b done=%b addr=%0d required 0",
                         u, load_s[u], valid_s[u], busy_s[u], done_s[u], addr_s[u]);
            end
        end
    endtask

    task automatic test_basic_frame();
        pulse_start(0);
        consume(0, 8, 100, 8, 0, 0);
        checks++;
        if (r_first_valid !== 3) begin
            failures++;
            $display("FAIL first_latency got=%0d required=3", r_first_valid);
        end
        checks++;
        if (r_accepted !== 8 || r_loads !== 8 || r_done !== 0) begin
            failures++;
            $display("FAIL basic_counts accepted=%0d loads=%0d early_done=%0d required 8/8/0",
                     r_accepted, r_loads, r_done);
        end
    endtask

    task automatic test_backpressure();
        int nl;
        nl = 0;
        pulse_start(0);
        for (int c = 0; c < 20; c++) begin
            if (load_s[0]) begin
                checks++;
                if (addr_s[0] !== 13'(nl)) begin
                    failures++;
                    $display("FAIL stall_load_addr got=%0d required=%0d", addr_s[0], nl);
                end
                nl++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (nl !== 4) begin
            failures++;
            $display("FAIL stall_load_count got=%0d required=4", nl);
        end
        checks++;
        if (valid_s[0] !== 1'b1 || pdata_s[0] !== 32'd0 || sof_s[0] !== 1'b1) begin
            failures++;
            $display("FAIL stall_head valid=%b data=%h sof=%b required 1/0/1", valid_s[0], pdata_s[0], sof_s[0]);
        end
        consume(0, 8, 100, 8, 0, nl);
        checks++;
        if (r_accepted !== 8 || r_loads !== 8) begin
            failures++;
            $display("FAIL stall_release accepted=%0d loads=%0d required 8/8", r_accepted, r_loads);
        end
    endtask

    task automatic test_random_ready();
        salt[1] = $urandom;
        pulse_start(1);
        consume(1, 100, 50, 100, 0, 0);
        checks++;
        if (r_accepted !== 100 || r_loads !== 100 || r_done !== 0) begin
            failures++;
            $display("FAIL random_counts accepted=%0d loads=%0d early_done=%0d required 100/100/0",
                     r_accepted, r_loads, r_done);
        end
    endtask

    task automatic test_abort();
        salt[1] = $urandom;
        pulse_start(1);
        consume(1, 100, 100, 5, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (valid_s[1] || done_s[1] || busy_s[1] || load_s[1]) begin
                failures++;
                $display("FAIL abort_idle cyc=%0d valid=%b done=%b busy=%b load=%b required all 0",
                         c, valid_s[1], done_s[1], busy_s[1], load_s[1]);
            end
            @(posedge clk); #1;
        end
        salt[1] = $urandom;
        pulse_start(1);
        consume(1, 100, 70, 100, 0, 0);
        checks++;
        if (r_accepted !== 100 || r_loads !== 100 || r_done !== 0) begin
            failures++;
            $display("FAIL abort_restart accepted=%0d loads=%0d early_done=%0d required 100/100/0",
                     r_accepted, r_loads, r_done);
        end
    endtask

    task automatic test_start_while_busy();
        pulse_start(0);
        consume(0, 8, 100, 8, 2, 0);
        checks++;
        if (r_accepted !== 8 || r_loads !== 8) begin
            failures++;
            $display("FAIL busy_start accepted=%0d loads=%0d required 8/8", r_accepted, r_loads);
        end
`ifdef VRAM_SCAN_UNDERRUN_CNT_EN
        checks++;
        if (und_s[0] !== 16'd2) begin
            failures++;
            $display("FAIL underrun_count got=%0d required=2", und_s[0]);
        end
`endif
        pulse_start(0);
        checks++;
        if (busy_s[0] !== 1'b1) begin
            failures++;
            $display("FAIL restart_busy got=%b required=1", busy_s[0]);
        end
`ifdef VRAM_SCAN_UNDERRUN_CNT_EN
        checks++;
        if (und_s[0] !== 16'd0) begin
            failures++;
            $display("FAIL underrun_clear got=%0d required=0", und_s[0]);
        end
`endif
        consume(0, 8, 100, 8, 0, 0);
        checks++;
        if (r_accepted !== 8) begin
            failures++;
            $display("FAIL restart_frame accepted=%0d required=8", r_accepted);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            start_s[u] = 1'b0;
            ready_s[u] = 1'b0;
        end
        salt[0] = '0;
        salt[1] = $urandom;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_random_ready();
        test_abort();
        test_start_while_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
